// File: rtl/global_types.sv
// Shared widths for the header-field pipeline (get_field, ip_id_window, decision).
package global_types;

    localparam int IP_ID_SIZE     = 16;
    localparam int ID_WINDOW_SIZE = 32;

endpackage

// File: rtl/ip_id_window_entry.sv
// One window slot: stored value, occupied bit and its compare against the probe.
module ip_id_window_entry
    import global_types::*;
#(
    parameter int FIELD_SIZE = IP_ID_SIZE
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  we,
    input  logic [FIELD_SIZE-1:0] wdata,
    input  logic [FIELD_SIZE-1:0] field,
    output logic                  occupied,
    output logic                  hit
);

    logic [FIELD_SIZE-1:0] data;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            occupied <= 1'b0;
        end else if (we) begin
            occupied <= 1'b1;
        end else if (clear) begin
            occupied <= 1'b0;
        end
    end

    // Contents are meaningless until occupied is set, so no reset here.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            data <= wdata;
        end
    end

    assign hit = occupied & (data == field);

endmodule

// File: rtl/ip_id_window.sv
// Sliding-window duplicate detector: parallel compare against the last
// WINDOW_SIZE field values, FIFO-age replacement.
module ip_id_window
    import global_types::*;
#(
    parameter int FIELD_SIZE  = IP_ID_SIZE,
    parameter int WINDOW_SIZE = ID_WINDOW_SIZE,
    parameter int CNT_W       = 32,
    localparam int FILL_W     = $clog2(WINDOW_SIZE + 1),
    localparam int PTR_W      = $clog2(WINDOW_SIZE)
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [FIELD_SIZE-1:0] field,
    output logic                  found,
    output logic                  found_valid,
    output logic [FILL_W-1:0]     fill,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      lookup_count
);

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       wr_idx;
    logic [WINDOW_SIZE-1:0] hits;
    logic [WINDOW_SIZE-1:0] occ;
    logic                   match;

    // A flush in the same cycle redirects the write to slot 0.
    assign wr_idx = clear ? '0 : wr_ptr;
    assign match  = (|hits) & ~clear;

    for (genvar i = 0; i < WINDOW_SIZE; i++) begin : g_entry
        ip_id_window_entry #(
            .FIELD_SIZE(FIELD_SIZE)
        ) u_entry (
            .sys_clk (sys_clk),
            .reset_n (reset_n),
            .clear   (clear),
            .we      (valid && (wr_idx == PTR_W'(i))),
            .wdata   (field),
            .field   (field),
            .occupied(occ[i]),
            .hit     (hits[i])
        );
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            fill        <= '0;
            found       <= 1'b0;
            found_valid <= 1'b0;
        end else begin
            found_valid <= valid;
            if (valid) begin
                found <= match;
            end
            if (clear) begin
                wr_ptr <= valid ? PTR_W'(1) : '0;
                fill   <= valid ? FILL_W'(1) : '0;
            end else if (valid) begin
                wr_ptr <= (wr_ptr == PTR_W'(WINDOW_SIZE - 1)) ? '0 : wr_ptr + 1'b1;
                if (!occ[wr_ptr]) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count    <= '0;
            lookup_count <= '0;
        end else if (valid) begin
            lookup_count <= lookup_count + CNT_W'(1);
            if (match) begin
                hit_count <= hit_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ip_id_window.sv
// Bench for ip_id_window: directed scenarios plus random traffic against a
// queue-based model of the remembered values.
module tb_ip_id_window;

    localparam int FS = 16;
    localparam int W  = 4;
    localparam int CW = 32;
    localparam int FW = $clog2(W + 1);

    logic          sys_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear   = 1'b0;
    logic          valid   = 1'b0;
    logic [FS-1:0] field   = '0;
    logic          found;
    logic          found_valid;
    logic [FW-1:0] fill;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] lookup_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [FS-1:0] win[$];
    logic          m_found;
    logic          m_fv;
    int unsigned   m_hits;
    int unsigned   m_looks;

    ip_id_window #(
        .FIELD_SIZE (FS),
        .WINDOW_SIZE(W),
        .CNT_W      (CW)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .valid       (valid),
        .field       (field),
        .found       (found),
        .found_valid (found_valid),
        .fill        (fill),
        .hit_count   (hit_count),
        .lookup_count(lookup_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        win.delete();
        m_found = 1'b0;
        m_fv    = 1'b0;
        m_hits  = 0;
        m_looks = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fv"},    64'(found_valid),  64'(m_fv));
        chk({tag, ".found"}, 64'(found),        64'(m_found));
        chk({tag, ".fill"},  64'(fill),         64'(win.size()));
        chk({tag, ".hits"},  64'(hit_count),    64'(m_hits));
        chk({tag, ".looks"}, 64'(lookup_count), 64'(m_looks));
    endtask

    task automatic step(input string tag, input bit v, input bit c,
                        input logic [FS-1:0] f);
        bit hit;
        @(negedge sys_clk);
        valid = v;
        clear = c;
        field = f;
        if (c) win.delete();
        m_fv = v;
        if (v) begin
            hit = 1'b0;
            foreach (win[k]) if (win[k] == f) hit = 1'b1;
            m_found = hit;
            m_looks++;
            if (hit) m_hits++;
            win.push_back(f);
            if (win.size() > W) void'(win.pop_front());
        end
        @(posedge sys_clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        reset_n = 1'b0;
        valid   = 1'b0;
        clear   = 1'b0;
        m_reset();
        #1;
        check_all("rst");
        @(negedge sys_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        check_all("por");
        @(negedge sys_clk);
        reset_n = 1'b1;

        // single lookup into an empty window
        step("t1", 1, 0, 16'h1234);
        chk("t1.found_k", 64'(found), 64'd0);
        step("t1i", 0, 0, 16'h0);
        do_reset();

        // 1,2,3,2 -> last is a hit
        step("t2a", 1, 0, 16'd1);
        step("t2b", 1, 0, 16'd2);
        step("t2c", 1, 0, 16'd3);
        step("t2d", 1, 0, 16'd2);
        chk("t2.found_k", 64'(found), 64'd1);
        chk("t2.fill_k", 64'(fill), 64'd4);
        do_reset();

        // eviction at full window
        for (int i = 10; i <= 14; i++) step("t3w", 1, 0, FS'(i));
        step("t3a", 1, 0, 16'd10);
        chk("t3a.found_k", 64'(found), 64'd0);
        step("t3b", 1, 0, 16'd11);
        chk("t3b.found_k", 64'(found), 64'd0);
        step("t3c", 1, 0, 16'd14);
        chk("t3c.found_k", 64'(found), 64'd1);
        do_reset();

        // repeated value
        for (int i = 0; i < 3; i++) step("t4", 1, 0, 16'hBEEF);
        chk("t4.found_k", 64'(found), 64'd1);
        step("t4n", 1, 0, 16'h0001);
        do_reset();

        // clear with concurrent lookup
        for (int i = 0; i < W; i++) step("t5w", 1, 0, 16'd5);
        step("t5c", 1, 1, 16'd5);
        chk("t5c.found_k", 64'(found), 64'd0);
        chk("t5c.fill_k", 64'(fill), 64'd1);
        step("t5n", 1, 0, 16'd5);
        chk("t5n.found_k", 64'(found), 64'd1);
        step("t5i", 0, 1, 16'd0);
        step("t5e", 1, 0, 16'd5);

        // async reset with a found_valid pulse in flight
        step("t6a", 1, 0, 16'h0077);
        step("t6b", 1, 0, 16'h0078);
        #2;
        reset_n = 1'b0;
        valid   = 1'b0;
        m_reset();
        #1;
        check_all("t6r");
        @(negedge sys_clk);
        reset_n = 1'b1;
        step("t6c", 1, 0, 16'h0077);
        chk("t6c.found_k", 64'(found), 64'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            step("rnd",
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0,
                 FS'($urandom_range(0, 9)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
